skullfet_cell_checker: RTL and testbench

//   Stimulus-and-check engine for one skullfet_inverter and one skullfet_nand instance.

---
 rtl/skullfet_cell_checker.sv | 124 ++++++++++++
 tb/tb_skullfet_cell_checker.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/skullfet_cell_checker.sv
// skullfet_cell_checker: sweeps the four input vectors through one skullfet inverter and one nand,
// checks each Y against its truth table and reports saturating mismatch counts and pass/fail.
module skullfet_cell_checker #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    input  logic             continuous,
    output logic             inv_a,
    output logic             nand_a,
    output logic             nand_b,
    input  logic             inv_y,
    input  logic             nand_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic             fail_inv,
    output logic             fail_nand,
    output logic [1:0]       first_fail_vec
);
    localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FIN} state_t;

    state_t           state_q, state_d;
    logic [1:0]       v_q, v_d, ffv_q, ffv_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic             fail_inv_q, fail_inv_d, fail_nand_q, fail_nand_d;
    logic [CNT_W-1:0] err_q, err_d, err_sat;
    logic [CNT_W:0]   sum;
    logic             inv_bad, nand_bad;

    always_comb begin
        // case equality so an X/Z from a cell is a mismatch rather than a silent pass
        inv_bad     = inv_y !== ~v_q[1];
        nand_bad    = nand_y !== ~(v_q[1] & v_q[0]);
        sum         = {1'b0, err_q} + (CNT_W+1)'(inv_bad) + (CNT_W+1)'(nand_bad);
        err_sat     = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        state_d     = state_q;
        v_d         = v_q;
        settle_d    = settle_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_d       = err_q;
        fail_inv_d  = fail_inv_q;
        fail_nand_d = fail_nand_q;
        ffv_d       = ffv_q;
        case (state_q)
            IDLE: if (start) begin
                state_d     = DRIVE;
                v_d         = 2'd0;
                settle_d    = '0;
                busy_d      = 1'b1;
                pass_d      = 1'b0;
                err_d       = '0;
                fail_inv_d  = 1'b0;
                fail_nand_d = 1'b0;
                ffv_d       = 2'd0;
            end
            DRIVE: begin
                state_d  = settle_q == SETTLE_LAST ? SAMPLE : DRIVE;
                settle_d = settle_q == SETTLE_LAST ? '0 : settle_q + SW'(1);
            end
            SAMPLE: begin
                err_d       = err_sat;
                fail_inv_d  = fail_inv_q | inv_bad;
                fail_nand_d = fail_nand_q | nand_bad;
                ffv_d       = (inv_bad | nand_bad) && !(fail_inv_q | fail_nand_q) ? v_q : ffv_q;
                v_d         = v_q + 2'd1;
                state_d     = DRIVE;
                if (v_q == 2'd3) begin
                    done_d  = 1'b1;
                    pass_d  = err_sat == '0;
                    state_d = continuous ? DRIVE : FIN;
                    busy_d  = continuous;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            v_q         <= 2'd0;
            settle_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            fail_inv_q  <= 1'b0;
            fail_nand_q <= 1'b0;
            ffv_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            settle_q    <= settle_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            fail_inv_q  <= fail_inv_d;
            fail_nand_q <= fail_nand_d;
            ffv_q       <= ffv_d;
        end
    end

    assign inv_a          = v_q[1];
    assign nand_a         = v_q[1];
    assign nand_b         = v_q[0];
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign fail_inv       = fail_inv_q;
    assign fail_nand      = fail_nand_q;
    assign first_fail_vec = ffv_q;
endmodule

// File: tb/tb_skullfet_cell_checker.sv
// tb_skullfet_cell_checker: directed vectors against a default instance with modelled cells and
// faults, plus a CNT_W=2 instance fed unknown Y values to exercise saturation.
module tb_skullfet_cell_checker;
    logic        clk = 1'b0, rst = 1'b1;
    logic        start = 1'b0, cont = 1'b0, start2 = 1'b0, cont2 = 1'b0;
    int          mode = 0;
    logic        inv_a, nand_a, nand_b, inv_y, nand_y, busy, done, pass, fail_inv, fail_nand;
    logic [15:0] err_count;
    logic [1:0]  ffv;
    logic        inv_a2, nand_a2, nand_b2, busy2, done2, pass2, fail_inv2, fail_nand2;
    logic [1:0]  err2, ffv2;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    // mode 0 = real cells, 1 = inv stuck 0, 2 = nand stuck 1, 3 = inv stuck 1, 4 = nand stuck 0
    assign inv_y  = mode == 1 ? 1'b0 : mode == 3 ? 1'b1 : ~inv_a;
    assign nand_y = mode == 2 ? 1'b1 : mode == 4 ? 1'b0 : ~(nand_a & nand_b);

    skullfet_cell_checker dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .continuous(cont),
        .inv_a(inv_a), .nand_a(nand_a), .nand_b(nand_b), .inv_y(inv_y), .nand_y(nand_y),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_inv(fail_inv), .fail_nand(fail_nand), .first_fail_vec(ffv)
    );

    skullfet_cell_checker #(.SETTLE_CYCLES(4), .CNT_W(2)) dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start2), .continuous(cont2),
        .inv_a(inv_a2), .nand_a(nand_a2), .nand_b(nand_b2), .inv_y(1'bx), .nand_y(1'bx),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_inv(fail_inv2), .fail_nand(fail_nand2), .first_fail_vec(ffv2)
    );

    typedef struct {
        int          mode;
        logic [15:0] err;
        logic        fi;
        logic        fn;
        logic [1:0]  ffv;
        logic        pass;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse;
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Checks busy and the driven vector for cycles 1..n of a sweep; returns in cycle n+1.
    task automatic run_cycles(input int first, input int n);
        logic [1:0] v;
        for (int c = first; c < first + n; c++) begin
            v = 2'(((c - 1) % 20) / 5);
            chk("busy", busy, 1);
            chk("vec", {inv_a, nand_a, nand_b}, {v[1], v[1], v[0]});
            if ((c - 1) % 20 != 0) chk("done_low", done, 0);
            tick();
        end
    endtask

    initial begin
        tbl[0] = '{1, 16'd2, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[1] = '{0, 16'd0, 1'b0, 1'b0, 2'd0, 1'b1};
        tbl[2] = '{2, 16'd1, 1'b0, 1'b1, 2'd3, 1'b0};
        tbl[3] = '{3, 16'd2, 1'b1, 1'b0, 2'd2, 1'b0};
        tbl[4] = '{4, 16'd3, 1'b0, 1'b1, 2'd0, 1'b0};

        #1;
        chk("reset_outs", {busy, done, pass, err_count, fail_inv, fail_nand, ffv, inv_a, nand_a, nand_b},
            0);
        chk("reset_outs2", {busy2, done2, pass2, err2, fail_inv2, fail_nand2, ffv2}, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        foreach (tbl[i]) begin
            mode = tbl[i].mode;
            start_pulse();
            chk("cleared_err", err_count, 0);
            run_cycles(1, 20);
            chk("fin_done", done, 1);
            chk("fin_busy", busy, 0);
            chk("fin_inputs", {inv_a, nand_a, nand_b}, 0);
            chk("err_count", err_count, tbl[i].err);
            chk("fail_inv", fail_inv, tbl[i].fi);
            chk("fail_nand", fail_nand, tbl[i].fn);
            chk("first_fail_vec", ffv, tbl[i].ffv);
            chk("pass", pass, tbl[i].pass);
            tick();
            tick();
            chk("done_pulse_end", done, 0);
            chk("pass_held", pass, tbl[i].pass);
        end

        // continuous sweeps, inverter stuck 0: two mismatches per sweep
        mode = 1;
        cont = 1'b1;
        start_pulse();
        run_cycles(1, 20);
        chk("c1_done", done, 1);
        chk("c1_busy", busy, 1);
        chk("c1_err", err_count, 2);
        run_cycles(21, 20);
        chk("c2_done", done, 1);
        chk("c2_err", err_count, 4);
        run_cycles(41, 20);
        chk("c3_done", done, 1);
        chk("c3_busy", busy, 1);
        chk("c3_err", err_count, 6);
        chk("c3_pass", pass, 0);
        cont = 1'b0;
        run_cycles(61, 20);
        chk("c_fin_done", done, 1);
        chk("c_fin_busy", busy, 0);
        chk("c_fin_err", err_count, 8);
        tick();

        // async reset during DRIVE of v=2, then a fresh start from v=0
        start_pulse();
        run_cycles(1, 11);
        chk("pre_rst_vec", {inv_a, nand_b}, 2'b10);
        chk("pre_rst_err", err_count, 2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst", {busy, done, pass, err_count, fail_inv, fail_nand, ffv, inv_a, nand_a, nand_b},
            0);
        @(negedge clk);
        rst = 1'b0;
        start_pulse();
        run_cycles(1, 20);
        chk("restart_done", done, 1);
        chk("restart_err", err_count, 2);
        chk("restart_ffv", ffv, 0);
        tick();

        // narrow counter with unknown outputs saturates; start while busy is ignored
        cont2 = 1'b1;
        @(negedge clk);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (40) tick();
        chk("sat_done", done2, 1);
        chk("sat_err", err2, 3);
        chk("sat_fails", {fail_inv2, fail_nand2}, 2'b11);
        @(negedge clk);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("busy_start_err", err2, 3);
        chk("busy_start_busy", busy2, 1);
        cont2 = 1'b0;
        begin
            int n = 0;
            while (!done2 && n < 30) begin
                tick();
                n++;
            end
            chk("sat_fin_seen", n < 30, 1);
        end
        chk("sat_fin_busy", busy2, 0);
        chk("sat_fin_err", err2, 3);
        chk("sat_fin_pass", pass2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
